// File: rtl/serial_adder.sv
// Bit-serial adder: one registered full-adder cell, LSB first, with a start/busy/done handshake.
// Optional subtract mode and signed-overflow flag are enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_SUB_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             c_next;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // The single full-adder cell shared by every bit position.
  assign s      = a_sr[0] ^ b_sr[0] ^ c;
  assign c_next = (a_sr[0] & b_sr[0]) | (b_sr[0] & c) | (a_sr[0] & c);

  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_next = s;
    end else begin : g_sum_wn
      assign sum_next = {s, sum[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_ADDER_SUB_EN
  // a - b - cin computed as a + ~b + ~cin.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? ~cin : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            c     <= c_load;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          c    <= c_next;
          sum  <= sum_next;
          if (cnt == LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= c_next;
`ifdef SERIAL_ADDER_SUB_EN
            // c is the carry into the MSB on the last cell evaluation.
            ovf   <= c ^ c_next;
`endif
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); covers reset, add, ripple,
// ignored start, back-to-back, abort, and the subtract mode when SERIAL_ADDER_SUB_EN is set.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDER_SUB_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances until done is seen or a bound expires; n is the number of edges taken.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
  endtask

  task automatic check_idle(input string tag, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_sum"},  64'(sum),  64'(exp_sum));
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
  endtask

  // Accepts one operation, then checks busy, latency and the result.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vc, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int n;
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    wait_done(n);
    check({tag, "_latency"}, 64'(n), 64'(WIDTH));
    check({tag, "_sum"},  64'(sum),  64'(exp_sum));
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    tick();
    check_idle({tag, "_hold"}, exp_sum, exp_cout);
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif

    // Reset wins over start for two cycles.
    tick();
    check_idle("rst1", 8'h00, 1'b0);
    tick();
    check_idle("rst2", 8'h00, 1'b0);
    rst = 1'b0; start = 1'b0;
    tick();
    check_idle("idle", 8'h00, 1'b0);

    run_op("add",    8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    run_op("ripple", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run_op("ffff",   8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Second start during RUN cycle 3 must be ignored.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'h01; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    n = 3;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("ign_latency", 64'(n), 64'(WIDTH));
    check("ign_sum",  64'(sum),  64'h30);
    check("ign_cout", 64'(cout), 64'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    check("ign_extra_done", 64'(pulses), 64'd0);

    // Back-to-back with start held high.
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    tick();
    a = 8'h01; b = 8'h02;
    wait_done(n);
    check("b2b1_latency", 64'(n), 64'(WIDTH));
    check("b2b1_sum",  64'(sum),  64'h00);
    check("b2b1_cout", 64'(cout), 64'd1);
    wait_done(n);
    check("b2b2_spacing", 64'(n), 64'(WIDTH + 1));
    check("b2b2_sum",  64'(sum),  64'h03);
    check("b2b2_cout", 64'(cout), 64'd0);
    start = 1'b0;
    tick();
    check("b2b2_done_drop", 64'(done), 64'd0);

    // Make cout nonzero first so the abort's clear is visible.
    run_op("pre_abort", 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1);

    // Abort mid-RUN with reset.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("abort", 8'h00, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op("sub_borrow", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0);
    check("sub_borrow_ovf", 64'(ovf), 64'd0);
    run_op("sub_ovf", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1);
    check("sub_ovf_ovf", 64'(ovf), 64'd1);
    sub = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the team's single-bit full adder.
- Adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
- Uses one registered full-adder cell (sum = a^b^c, carry = ab|bc|ac) and a start/busy/done handshake.
- Serves as the area-minimal adder for datapaths that can tolerate WIDTH-cycle latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; sampled with an accepted start.
- b  input  WIDTH  operand B; sampled with an accepted start.
- cin  input  1  carry-in; sampled with an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; marks sum and cout valid.
- sum  output  WIDTH  result bits, registered.
- cout  output  1  carry out of bit WIDTH-1, registered.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry register and bit counter cleared.
- States: IDLE, RUN, DONE; encoding is free.
- Start acceptance (IDLE or DONE, start=1):
  - latch a and b into shift registers; carry register <= cin; counter <= 0.
  - state -> RUN; busy=1 from the next cycle.
  - sum is cleared on acceptance.
- Start in DONE is accepted: back-to-back operations are allowed, and done still pulses for the previous result in that cycle.
- RUN, each cycle:
  - s = a_sr[0] ^ b_sr[0] ^ c; c <= (a_sr[0]&b_sr[0]) | (b_sr[0]&c) | (a_sr[0]&c).
  - s shifts into sum from the MSB side (sum <= {s, sum[WIDTH-1:1]}), so after WIDTH shifts bit i sits in sum[i].
  - a_sr and b_sr shift right; counter increments.
- Leaving RUN: on the WIDTH-th RUN cycle, state -> DONE, cout <= final carry, done <= 1.
- Latency: start sampled at edge t; done high in the cycle after edge t+WIDTH. Throughput is one result per WIDTH+1 cycles.
- DONE lasts one cycle (done=1, busy=0), then goes to IDLE unless start was accepted.
- done is never high for more than one consecutive cycle unless back-to-back operations complete.
- Result hold: sum and cout hold their last valid values in IDLE until the next accepted start.
- Ignored inputs: start while busy=1 is ignored, and a, b, cin are don't-care while busy.
- Arithmetic: {cout,sum} == a + b + cin, evaluated at WIDTH+1 bits.
- Counter width: $clog2(WIDTH+1). For WIDTH=1, RUN lasts exactly one cycle.
- Reset mid-RUN: the operation is aborted with no done pulse, and all outputs return to reset values on the next edge.
- Reset has priority over start in the same cycle.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - add input port sub (1 bit), sampled with an accepted start.
  - When sub=1: b is inverted on load, and the carry register loads ~cin, so the result is a - b - cin.
  - cout=1 means no borrow.
  - add output ovf (1 bit, reset 0) = signed overflow, i.e. carry into bit WIDTH-1 XOR carry out; it is updated with cout and held like cout.
- When undefined:
  - no sub or ovf ports; behaviour is addition only as above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with start=1 -> busy=0, done=0, sum=0x00, cout=0 throughout.
- Basic add, WIDTH=8: a=0x35, b=0x4A, cin=0 -> busy for 8 cycles; done pulse at edge t+9 (sampled); sum=0x7F, cout=0.
- Full carry ripple: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Ignored start: start again with a=0x01, b=0x01 at RUN cycle 3 of a=0x10 + b=0x20 -> result 0x30, cout=0. The second request is ignored and no extra done pulse occurs.
- Back-to-back and abort:
  - start held high continuously with 0x80+0x80 then 0x01+0x02 -> first done gives sum=0x00, cout=1; next done exactly 9 cycles later gives 0x03, cout=0.
  - rst pulsed at RUN cycle 4 -> no done pulse; outputs are 0.
- SERIAL_ADDER_SUB_EN defined: sub=1, a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0 (borrow). Also a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1.
